// File: rtl/max11046_pkg.sv
// Shared state encoding, parameter defaults and a counter-sizing helper for the
// MAX11046 readout controller.
package max11046_pkg;

    localparam int unsigned DEF_NUM_CH      = 8;
    localparam int unsigned DEF_CONVST_CYC  = 2;
    localparam int unsigned DEF_RD_LOW_CYC  = 2;
    localparam int unsigned DEF_SER_CYC     = 16;
    localparam int unsigned DEF_EOC_TIMEOUT = 1023;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CONVST   = 3'd1;
    localparam logic [2:0] ST_WAIT_EOC = 3'd2;
    localparam logic [2:0] ST_RD_LOW   = 3'd3;
    localparam logic [2:0] ST_RD_HIGH  = 3'd4;
    localparam logic [2:0] ST_LOAD     = 3'd5;
    localparam logic [2:0] ST_SHIFT    = 3'd6;
    localparam logic [2:0] ST_DONE     = 3'd7;

    // Width of one shared phase counter that must hold the largest of its limits.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/max11046_eoc_sync.sv
// Two-flop synchronizer for the asynchronous, active-low ADC end-of-conversion.
module max11046_eoc_sync (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_async_n,
    output logic o_sync_n
);

    logic r_meta_n;
    logic r_sync_n;

    // Both stages reset to the idle (high) level so no false EOC follows reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_meta_n <= 1'b1;
            r_sync_n <= 1'b1;
        end else begin
            r_meta_n <= i_async_n;
            r_sync_n <= r_meta_n;
        end
    end

    assign o_sync_n = r_sync_n;

endmodule

// File: rtl/max11046_readout_ctrl.sv
// MAX11046 conversion/readout sequencer: starts a conversion, waits for EOC,
// reads NUM_CH samples and hands each to a downstream serializer.
module max11046_readout_ctrl
    import max11046_pkg::*;
#(
    parameter int unsigned NUM_CH      = DEF_NUM_CH,      // 1..8
    parameter int unsigned CONVST_CYC  = DEF_CONVST_CYC,  // >= 1
    parameter int unsigned RD_LOW_CYC  = DEF_RD_LOW_CYC,  // >= 1
    parameter int unsigned SER_CYC     = DEF_SER_CYC,     // >= 1
    parameter int unsigned EOC_TIMEOUT = DEF_EOC_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        adc_eoc_n,
    input  logic [15:0] adc_db,
    output logic        adc_convst_n,
    output logic        adc_cs_n,
    output logic        adc_rd_n,
    output logic [15:0] parallel_data_out,
    output logic        loaden_o,
    output logic [2:0]  ch_idx,
    output logic        busy,
    output logic        frame_done,
    output logic        eoc_timeout
);

    localparam int unsigned CW = cnt_width(CONVST_CYC, RD_LOW_CYC, SER_CYC, EOC_TIMEOUT);

    logic [2:0]    r_state;
    logic [2:0]    w_state_d;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_d;
    logic [2:0]    r_ch;
    logic [2:0]    w_ch_d;
    logic [15:0]   r_data;
    logic          w_capture;
    logic          w_timeout;
    logic          w_eoc_n_sync;

    logic r_convst_n;
    logic r_cs_n;
    logic r_rd_n;
    logic r_load;
    logic r_busy;
    logic r_done;

    max11046_eoc_sync u_eoc_sync (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_async_n (adc_eoc_n),
        .o_sync_n  (w_eoc_n_sync)
    );

    // Next-state logic; the phase counter restarts at zero on every state change.
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = '0;
        w_ch_d    = r_ch;
        w_capture = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_d = ST_CONVST;
                    w_ch_d    = '0;
                end
            end
            ST_CONVST: begin
                if (r_cnt == CW'(CONVST_CYC - 1)) w_state_d = ST_WAIT_EOC;
                else                              w_cnt_d   = r_cnt + 1'b1;
            end
            ST_WAIT_EOC: begin
                if (!w_eoc_n_sync) begin
                    w_state_d = ST_RD_LOW;
                end else if (r_cnt == CW'(EOC_TIMEOUT)) begin
                    w_timeout = 1'b1;
                    w_state_d = ST_IDLE;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            ST_RD_LOW: begin
                if (r_cnt == CW'(RD_LOW_CYC - 1)) begin
                    w_capture = 1'b1;
                    w_state_d = ST_RD_HIGH;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            ST_RD_HIGH: w_state_d = ST_LOAD;
            ST_LOAD:    w_state_d = ST_SHIFT;
            ST_SHIFT: begin
                if (r_cnt == CW'(SER_CYC - 1)) begin
                    if (r_ch == 3'(NUM_CH - 1)) begin
                        w_state_d = ST_DONE;
                    end else begin
                        w_ch_d    = r_ch + 3'd1;
                        w_state_d = ST_RD_LOW;
                    end
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            ST_DONE:  w_state_d = ST_IDLE;
            default:  w_state_d = ST_IDLE;
        endcase
    end

    // State, counters and outputs; strobes are decoded from the next state so they
    // come straight from flops and line up exactly with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_ch       <= '0;
            r_data     <= '0;
            r_convst_n <= 1'b1;
            r_cs_n     <= 1'b1;
            r_rd_n     <= 1'b1;
            r_load     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_cnt      <= w_cnt_d;
            r_ch       <= w_ch_d;
            if (w_capture) r_data <= adc_db;
            r_convst_n <= (w_state_d != ST_CONVST);
            r_cs_n     <= !(w_state_d inside {ST_RD_LOW, ST_RD_HIGH, ST_LOAD, ST_SHIFT});
            r_rd_n     <= (w_state_d != ST_RD_LOW);
            r_load     <= (w_state_d == ST_LOAD);
            r_busy     <= (w_state_d != ST_IDLE);
            r_done     <= (w_state_d == ST_DONE);
        end
    end

    assign adc_convst_n      = r_convst_n;
    assign adc_cs_n          = r_cs_n;
    assign adc_rd_n          = r_rd_n;
    assign parallel_data_out = r_data;
    assign loaden_o          = r_load;
    assign ch_idx            = r_ch;
    assign busy              = r_busy;
    assign frame_done        = r_done;
    // Pulses in the last WAIT_EOC cycle; busy drops on the following cycle.
    assign eoc_timeout       = w_timeout & ~reset;

endmodule

// File: tb/tb_max11046_readout_ctrl.sv
// Directed bench for max11046_readout_ctrl: default instance plus a one-channel,
// three-cycle-read instance.
module tb_max11046_readout_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        adc_eoc_n = 1'b1;
    logic [15:0] adc_db;
    logic        adc_convst_n, adc_cs_n, adc_rd_n, loaden_o, busy, frame_done, eoc_timeout;
    logic [15:0] parallel_data_out;
    logic [2:0]  ch_idx;

    logic        start1 = 1'b0;
    logic        adc_eoc1_n = 1'b1;
    logic [15:0] adc_db1 = 16'hBEEF;
    logic        convst1_n, cs1_n, rd1_n, load1, busy1, done1, to1;
    logic [15:0] pdo1;
    logic [2:0]  ch1;

    int checks = 0;
    int errors = 0;

    // Monitor state (written only by the monitor process).
    int          cyc = 0;
    int          rd_fall = 0;
    int          eoc_cnt = 0;
    int          n_load = 0, n_done = 0, n_cv = 0, t_wait = 0, t_to = 0;
    logic [15:0] ld_data [0:63];
    logic [2:0]  ld_ch [0:63];
    int          ld_cyc [0:63];
    logic        prev_cv = 1'b1, prev_rd = 1'b1, prev_rd1 = 1'b1;
    int          n_rd1 = 0, n_load1 = 0, t_load1 = 0, n_done1 = 0, t_done1 = 0;
    logic [15:0] d1 = '0;
    logic        eoc_en = 1'b1;

    assign adc_db = 16'h1000 + 16'(rd_fall - 1);

    always #5 clk = ~clk;

    max11046_readout_ctrl u_dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .adc_eoc_n         (adc_eoc_n),
        .adc_db            (adc_db),
        .adc_convst_n      (adc_convst_n),
        .adc_cs_n          (adc_cs_n),
        .adc_rd_n          (adc_rd_n),
        .parallel_data_out (parallel_data_out),
        .loaden_o          (loaden_o),
        .ch_idx            (ch_idx),
        .busy              (busy),
        .frame_done        (frame_done),
        .eoc_timeout       (eoc_timeout)
    );

    max11046_readout_ctrl #(
        .NUM_CH     (1),
        .RD_LOW_CYC (3)
    ) u_dut1 (
        .clk               (clk),
        .reset             (reset),
        .start             (start1),
        .adc_eoc_n         (adc_eoc1_n),
        .adc_db            (adc_db1),
        .adc_convst_n      (convst1_n),
        .adc_cs_n          (cs1_n),
        .adc_rd_n          (rd1_n),
        .parallel_data_out (pdo1),
        .loaden_o          (load1),
        .ch_idx            (ch1),
        .busy              (busy1),
        .frame_done        (done1),
        .eoc_timeout       (to1)
    );

    // Negedge monitor plus ADC model: EOC falls 20 cycles after CONVST falls and
    // rises again on the first read strobe; data is 0x1000 + read index.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (prev_cv && !adc_convst_n) begin
            eoc_cnt = 20;
            rd_fall = 0;
        end
        if (eoc_cnt > 0) begin
            eoc_cnt--;
            if (eoc_cnt == 0 && eoc_en) adc_eoc_n = 1'b0;
        end
        if (prev_rd && !adc_rd_n) begin
            rd_fall++;
            adc_eoc_n = 1'b1;
        end
        if (!adc_convst_n) n_cv++;
        if (!prev_cv && adc_convst_n && busy) t_wait = cyc;
        if (eoc_timeout) t_to = cyc;
        if (loaden_o && n_load < 64) begin
            ld_data[n_load] = parallel_data_out;
            ld_ch[n_load]   = ch_idx;
            ld_cyc[n_load]  = cyc;
            n_load++;
        end
        if (frame_done) n_done++;
        prev_cv = adc_convst_n;
        prev_rd = adc_rd_n;
        if (!rd1_n) n_rd1++;
        if (load1) begin
            n_load1++;
            t_load1 = cyc;
            d1 = pdo1;
        end
        if (done1) begin
            n_done1++;
            t_done1 = cyc;
        end
        prev_rd1 = rd1_n;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle; lands just after the monitor's negedge sample.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_until(input int sel, input int budget, input string tag);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if ((sel == 0 && frame_done) || (sel == 1 && eoc_timeout) ||
                (sel == 2 && done1) || (sel == 3 && loaden_o && ch_idx == 3'd3)) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) begin
            checks++;
            errors++;
            $error("FAIL %s observed=timeout expected=event within %0d cycles", tag, budget);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_convst_n"}, 32'(adc_convst_n), 32'd1);
        chk({tag, "_cs_n"}, 32'(adc_cs_n), 32'd1);
        chk({tag, "_rd_n"}, 32'(adc_rd_n), 32'd1);
        chk({tag, "_loaden"}, 32'(loaden_o), 32'd0);
        chk({tag, "_pdo"}, 32'(parallel_data_out), 32'd0);
        chk({tag, "_ch"}, 32'(ch_idx), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_timeout"}, 32'(eoc_timeout), 32'd0);
    endtask

    initial begin
        int lb, db, cb, nl, nd, rb;

        // Reset state
        repeat (3) step();
        chk_reset_vals("rst");
        reset = 1'b0;
        repeat (2) step();

        // Full default frame: 8 loads, data 0x1000+ch, spacing 2+16+2
        lb = n_load; db = n_done; cb = n_cv;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_until(0, 2000, "frame1_wait");
        chk("f1_loads", 32'(n_load - lb), 32'd8);
        chk("f1_done_cnt", 32'(n_done - db), 32'd1);
        chk("f1_convst_w", 32'(n_cv - cb), 32'd2);
        chk("f1_cs_in_done", 32'(adc_cs_n), 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk("f1_data", 32'(ld_data[lb + i]), 32'h1000 + 32'(i));
            chk("f1_ch", 32'(ld_ch[lb + i]), 32'(i));
        end
        for (int i = 0; i < 7; i++) begin
            chk("f1_spacing", 32'(ld_cyc[lb + i + 1] - ld_cyc[lb + i]), 32'd20);
        end
        step();
        chk("f1_idle_busy", 32'(busy), 32'd0);

        // EOC never arrives: timeout 1023 cycles into WAIT_EOC, no loads
        eoc_en = 1'b0;
        lb = n_load;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_until(1, 1200, "timeout_wait");
        chk("to_delay", 32'(t_to - t_wait), 32'd1023);
        chk("to_busy_during", 32'(busy), 32'd1);
        step();
        chk("to_busy_after", 32'(busy), 32'd0);
        chk("to_pulse_len", 32'(eoc_timeout), 32'd0);
        chk("to_loads", 32'(n_load - lb), 32'd0);
        eoc_en = 1'b1;
        repeat (2) step();

        // start held high: one frame, then a new one only from IDLE
        lb = n_load; db = n_done;
        start = 1'b1;
        wait_until(0, 2000, "hold_wait1");
        chk("hold_loads1", 32'(n_load - lb), 32'd8);
        chk("hold_done1", 32'(n_done - db), 32'd1);
        step();
        chk("hold_idle_busy", 32'(busy), 32'd0);
        step();
        chk("hold_restart_busy", 32'(busy), 32'd1);
        chk("hold_restart_cv", 32'(adc_convst_n), 32'd0);
        start = 1'b0;
        wait_until(0, 2000, "hold_wait2");
        chk("hold_done2", 32'(n_done - db), 32'd2);
        chk("hold_loads2", 32'(n_load - lb), 32'd16);
        repeat (2) step();

        // Reset during SHIFT of channel 3
        start = 1'b1;
        step();
        start = 1'b0;
        wait_until(3, 2000, "ch3_wait");
        repeat (5) step();
        chk("mid_ch", 32'(ch_idx), 32'd3);
        chk("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        step();
        chk_reset_vals("abort");
        nl = n_load; nd = n_done;
        repeat (2) step();
        reset = 1'b0;
        repeat (60) step();
        chk("abort_no_load", 32'(n_load - nl), 32'd0);
        chk("abort_no_done", 32'(n_done - nd), 32'd0);

        // NUM_CH=1, RD_LOW_CYC=3 instance
        rb = n_rd1; lb = n_load1;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        adc_eoc1_n = 1'b0;
        wait_until(2, 500, "one_ch_wait");
        adc_eoc1_n = 1'b1;
        chk("one_rd_low", 32'(n_rd1 - rb), 32'd3);
        chk("one_loads", 32'(n_load1 - lb), 32'd1);
        chk("one_done_gap", 32'(t_done1 - t_load1), 32'd17);
        chk("one_data", 32'(d1), 32'hBEEF);
        chk("one_done_cnt", 32'(n_done1), 32'd1);
        step();
        chk("one_idle", 32'(busy1), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/max11046_readout_ctrl.md
MAX11046_READOUT_CTRL -- requirements
Module: max11046_readout_ctrl

Interface
REQ-001 Parameter NUM_CH, default 8: channels read per conversion frame (1..8).
REQ-002 Parameter CONVST_CYC, default 2: adc_convst_n low width in clk cycles.
REQ-003 Parameter RD_LOW_CYC, default 2: adc_rd_n low width per channel read.
REQ-004 Parameter SER_CYC, default 16: cycles reserved for the downstream serializer after each load strobe.
REQ-005 Parameter EOC_TIMEOUT, default 1023: max cycles waited for end-of-conversion.
REQ-006 clk  in  1  single clock for all logic.
REQ-007 reset  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-008 start  in  1  request one conversion frame; sampled only in IDLE.
REQ-009 adc_eoc_n  in  1  ADC end-of-conversion, active low, asynchronous to clk.
REQ-010 adc_db  in  16  ADC parallel data bus.
REQ-011 adc_convst_n  out  1  conversion start to ADC, active low.
REQ-012 adc_cs_n  out  1  ADC chip select, active low.
REQ-013 adc_rd_n  out  1  ADC read strobe, active low.
REQ-014 parallel_data_out  out  16  captured sample, feeds serializer parallel_data_in.
REQ-015 loaden_o  out  1  one-cycle load strobe to serializer.
REQ-016 ch_idx  out  3  channel index of parallel_data_out.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 frame_done  out  1  one-cycle pulse after last channel.
REQ-019 eoc_timeout  out  1  one-cycle pulse on end-of-conversion timeout.

Function
REQ-020 FSM states SHALL be IDLE, CONVST, WAIT_EOC, RD_LOW, RD_HIGH, LOAD, SHIFT, DONE.
REQ-021 IDLE -> CONVST on the edge where start=1; start SHALL be ignored in all other states.
REQ-022 CONVST: adc_convst_n low for exactly CONVST_CYC cycles, then WAIT_EOC with adc_convst_n high.
REQ-023 adc_eoc_n SHALL pass a two-flop synchronizer; WAIT_EOC exits to RD_LOW on first synchronized low.
REQ-024 WAIT_EOC counter reaching EOC_TIMEOUT without EOC: pulse eoc_timeout, return to IDLE, no loaden_o issued.
REQ-025 adc_cs_n SHALL go low on entry to the first RD_LOW and stay low until DONE.
REQ-026 RD_LOW: adc_rd_n low RD_LOW_CYC cycles; adc_db registered into parallel_data_out on the last low cycle.
REQ-027 RD_HIGH: adc_rd_n high exactly 1 cycle, then LOAD.
REQ-028 LOAD: loaden_o high exactly 1 cycle; parallel_data_out and ch_idx stable from LOAD through end of SHIFT.
REQ-029 SHIFT: SER_CYC cycles; then if ch_idx = NUM_CH-1 go DONE, else ch_idx+1 and RD_LOW.
REQ-030 ch_idx SHALL be 0 for the first channel of each frame and never wrap within a frame.
REQ-031 DONE: adc_cs_n high, frame_done high 1 cycle, next state IDLE; start in DONE is ignored.
REQ-032 Counters SHALL be sized to hold their max parameter value; no overflow wrap permitted.

Reset
REQ-033 While reset=1: state IDLE, adc_convst_n=1, adc_cs_n=1, adc_rd_n=1, loaden_o=0, parallel_data_out=0, ch_idx=0, busy=0, frame_done=0, eoc_timeout=0, synchronizer flops=1.
REQ-034 Reset asserted mid-frame SHALL abort immediately at that edge with no further loaden_o or frame_done.

Structure
REQ-035 State encoding and parameter defaults SHALL live in shared package max11046_pkg.
REQ-036 One sub-module, max11046_eoc_sync (two-flop synchronizer, reset value 1), SHALL be instantiated.

Verification
REQ-037 Defaults, start pulse, EOC low 20 cycles after CONVST, adc_db = 0x1000+ch -> 8 loaden_o pulses, parallel_data_out 0x1000..0x1007, ch_idx 0..7, one frame_done.
REQ-038 EOC never asserted -> eoc_timeout pulse 1023 cycles into WAIT_EOC, busy falls next cycle, zero loaden_o.
REQ-039 start held high through whole frame -> exactly one frame; second frame starts only on start sampled in IDLE.
REQ-040 reset asserted during SHIFT of ch 3 -> all outputs at REQ-033 values next cycle, no frame_done.
REQ-041 NUM_CH=1, RD_LOW_CYC=3 -> adc_rd_n low 3 cycles, one loaden_o, frame_done SER_CYC+1 cycles after loaden_o.
REQ-042 Inter-load spacing check -> consecutive loaden_o pulses exactly RD_LOW_CYC+SER_CYC+2 cycles apart.
